// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns simple cmd/rsp requests into AXI-Lite transactions.
// One transaction is in flight at a time; every handshake output is registered.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_write/addr/wdata/wstrb command fields (wdata/wstrb used for writes only)
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata/rsp_resp         read data (0 for writes), captured BRESP/RRESP
//   err_sticky/err_clear       sticky error flag, only with AXIL_CMD_MASTER_ERR_STICKY_EN
//   io_control_aw/w/b/ar/r_*   AXI-Lite master channels
//
// Build option: define AXIL_CMD_MASTER_ERR_STICKY_EN to add err_sticky/err_clear.
module axil_cmd_master #(
    parameter int AXI_LITE_ADDR_WIDTH = 6
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                    cmd_wdata,
    input  logic [3:0]                     cmd_wstrb,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_rdata,
    output logic [1:0]                     rsp_resp,
`ifdef AXIL_CMD_MASTER_ERR_STICKY_EN
    output logic                           err_sticky,
    input  logic                           err_clear,
`endif
    output logic [AXI_LITE_ADDR_WIDTH-1:0] io_control_aw_awaddr,
    output logic [2:0]                     io_control_aw_awprot,
    output logic                           io_control_aw_awvalid,
    input  logic                           io_control_aw_awready,
    output logic [31:0]                    io_control_w_wdata,
    output logic [3:0]                     io_control_w_wstrb,
    output logic                           io_control_w_wvalid,
    input  logic                           io_control_w_wready,
    input  logic [1:0]                     io_control_b_bresp,
    input  logic                           io_control_b_bvalid,
    output logic                           io_control_b_bready,
    output logic [AXI_LITE_ADDR_WIDTH-1:0] io_control_ar_araddr,
    output logic [2:0]                     io_control_ar_arprot,
    output logic                           io_control_ar_arvalid,
    input  logic                           io_control_ar_arready,
    input  logic [31:0]                    io_control_r_rdata,
    input  logic [1:0]                     io_control_r_rresp,
    input  logic                           io_control_r_rvalid,
    output logic                           io_control_r_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_B,
        S_AR,
        S_R,
        S_RSP
    } state_t;

    state_t state;

    logic [AXI_LITE_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]                    wdata_q;
    logic [3:0]                     wstrb_q;

    // A channel counts as done once its valid has dropped or is
    // handshaking this cycle; both may complete in the same cycle.
    logic aw_done;
    logic w_done;

    assign aw_done = !io_control_aw_awvalid || io_control_aw_awready;
    assign w_done  = !io_control_w_wvalid || io_control_w_wready;

    // Captured command fields drive the buses, so they stay stable
    // for the whole time any valid is high.
    assign io_control_aw_awaddr = addr_q;
    assign io_control_ar_araddr = addr_q;
    assign io_control_w_wdata   = wdata_q;
    assign io_control_w_wstrb   = wstrb_q;
    assign io_control_aw_awprot = 3'b000;
    assign io_control_ar_arprot = 3'b000;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                 <= S_IDLE;
            cmd_ready             <= 1'b1;
            io_control_aw_awvalid <= 1'b0;
            io_control_w_wvalid   <= 1'b0;
            io_control_b_bready   <= 1'b0;
            io_control_ar_arvalid <= 1'b0;
            io_control_r_rready   <= 1'b0;
            rsp_valid             <= 1'b0;
            rsp_rdata             <= '0;
            rsp_resp              <= '0;
            addr_q                <= '0;
            wdata_q               <= '0;
            wstrb_q               <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            state                 <= S_WRITE;
                            io_control_aw_awvalid <= 1'b1;
                            io_control_w_wvalid   <= 1'b1;
                        end else begin
                            state                 <= S_AR;
                            io_control_ar_arvalid <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (io_control_aw_awready) begin
                        io_control_aw_awvalid <= 1'b0;
                    end
                    if (io_control_w_wready) begin
                        io_control_w_wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        state               <= S_B;
                        io_control_b_bready <= 1'b1;
                    end
                end
                S_B: begin
                    if (io_control_b_bvalid) begin
                        state               <= S_RSP;
                        io_control_b_bready <= 1'b0;
                        rsp_resp            <= io_control_b_bresp;
                        rsp_rdata           <= '0;
                        rsp_valid           <= 1'b1;
                    end
                end
                S_AR: begin
                    if (io_control_ar_arready) begin
                        state                 <= S_R;
                        io_control_ar_arvalid <= 1'b0;
                        io_control_r_rready   <= 1'b1;
                    end
                end
                S_R: begin
                    if (io_control_r_rvalid) begin
                        state               <= S_RSP;
                        io_control_r_rready <= 1'b0;
                        rsp_rdata           <= io_control_r_rdata;
                        rsp_resp            <= io_control_r_rresp;
                        rsp_valid           <= 1'b1;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state                 <= S_IDLE;
                    cmd_ready             <= 1'b1;
                    io_control_aw_awvalid <= 1'b0;
                    io_control_w_wvalid   <= 1'b0;
                    io_control_b_bready   <= 1'b0;
                    io_control_ar_arvalid <= 1'b0;
                    io_control_r_rready   <= 1'b0;
                    rsp_valid             <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIL_CMD_MASTER_ERR_STICKY_EN
    logic err_set;

    assign err_set =
        (state == S_B && io_control_b_bvalid &&
         io_control_b_bresp != 2'b00) ||
        (state == S_R && io_control_r_rvalid &&
         io_control_r_rresp != 2'b00);

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_sticky <= 1'b0;
        end else if (err_set) begin
            err_sticky <= 1'b1;
        end else if (err_clear) begin
            err_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: table vectors, corner sequences and random traffic
// against a memory-backed AXI-Lite slave and a reference memory model.
module tb_axil_cmd_master;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
`ifdef AXIL_CMD_MASTER_ERR_STICKY_EN
    logic          err_sticky, err_clear;
`endif
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready;
    logic          bvalid, bready, arvalid, arready;
    logic          rvalid, rready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    axil_cmd_master #(.AXI_LITE_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
`ifdef AXIL_CMD_MASTER_ERR_STICKY_EN
        .err_sticky(err_sticky), .err_clear(err_clear),
`endif
        .io_control_aw_awaddr(awaddr), .io_control_aw_awprot(awprot),
        .io_control_aw_awvalid(awvalid), .io_control_aw_awready(awready),
        .io_control_w_wdata(wdata), .io_control_w_wstrb(wstrb),
        .io_control_w_wvalid(wvalid), .io_control_w_wready(wready),
        .io_control_b_bresp(bresp), .io_control_b_bvalid(bvalid),
        .io_control_b_bready(bready),
        .io_control_ar_araddr(araddr), .io_control_ar_arprot(arprot),
        .io_control_ar_arvalid(arvalid), .io_control_ar_arready(arready),
        .io_control_r_rdata(rdata), .io_control_r_rresp(rresp),
        .io_control_r_rvalid(rvalid), .io_control_r_rready(rready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- slave: memory with per-channel delays
    int          aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
    logic [1:0]  s_resp = 2'b00;
    logic [31:0] s_mem [16];
    int          n_b = 0, stab_err = 0, last_aw_hi = 0, last_w_hi = 0;

    initial begin : slave
        bit          mem_init;
        bit          aw_got, w_got, ar_got, b_on, b_fire, r_on, r_fire;
        int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_hi, w_hi;
        int          ar_hi;
        logic [AW-1:0] s_awaddr, s_araddr, ar_first;
        logic [31:0] s_wdata;
        logic [3:0]  s_wstrb;
        mem_init = 0;
        forever begin
            @(negedge clk or negedge rstn);
            if (!rstn) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rresp = 0; rdata = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
                b_on = 0; b_fire = 0; r_on = 0; r_fire = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_hi = 0; w_hi = 0; ar_hi = 0;
                if (!mem_init) begin
                    for (int i = 0; i < 16; i++) s_mem[i] = '0;
                    mem_init = 1;
                end
            end else begin
                if (awvalid) begin
                    aw_hi++;
                    if (aw_hi == 1) s_awaddr = awaddr;
                    else if (awaddr !== s_awaddr) stab_err++;
                end
                if (awready) begin
                    awready = 0; aw_got = 1;
                    last_aw_hi = aw_hi; aw_hi = 0;
                end else if (awvalid && !aw_got) begin
                    if (aw_cnt == aw_d) awready = 1;
                    else aw_cnt++;
                end
                if (wvalid) begin
                    w_hi++;
                    if (w_hi == 1) begin
                        s_wdata = wdata; s_wstrb = wstrb;
                    end else if (wdata !== s_wdata || wstrb !== s_wstrb)
                        stab_err++;
                end
                if (wready) begin
                    wready = 0; w_got = 1;
                    last_w_hi = w_hi; w_hi = 0;
                end else if (wvalid && !w_got) begin
                    if (w_cnt == w_d) wready = 1;
                    else w_cnt++;
                end
                if (b_fire) begin
                    bvalid = 0; b_fire = 0; b_on = 0; n_b++;
                    aw_got = 0; w_got = 0;
                    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                end else if (aw_got && w_got && !b_on) begin
                    if (b_cnt == b_d) begin
                        b_on = 1; bvalid = 1; bresp = s_resp;
                        for (int i = 0; i < 4; i++)
                            if (s_wstrb[i])
                                s_mem[s_awaddr[5:2]][8*i +: 8] =
                                    s_wdata[8*i +: 8];
                    end else b_cnt++;
                end
                if (bvalid && bready) b_fire = 1;
                if (arvalid) begin
                    ar_hi++;
                    if (ar_hi == 1) ar_first = araddr;
                    else if (araddr !== ar_first) stab_err++;
                end
                if (arready) begin
                    arready = 0; ar_got = 1; ar_hi = 0;
                end else if (arvalid && !ar_got) begin
                    if (ar_cnt == ar_d) begin
                        arready = 1; s_araddr = araddr;
                    end else ar_cnt++;
                end
                if (r_fire) begin
                    rvalid = 0; r_fire = 0; r_on = 0; ar_got = 0;
                    ar_cnt = 0; r_cnt = 0;
                end else if (ar_got && !r_on) begin
                    if (r_cnt == r_d) begin
                        r_on = 1; rvalid = 1; rresp = s_resp;
                        rdata = s_mem[s_araddr[5:2]];
                    end else r_cnt++;
                end
                if (rvalid && rready) r_fire = 1;
            end
        end
    end

    // ---------------- reference model
    logic [31:0] ref_mem [16];

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // ---------------- command driver
    task automatic run_txn(input bit wr, input logic [AW-1:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input int rsp_d,
                           output logic [31:0] grd,
                           output logic [1:0] grs, output int lat);
        int n;
        int hold_err;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk); n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk); lat++;
        end
        chk("rsp_valid_wait", 32'(rsp_valid), 1);
        grd = rsp_rdata; grs = rsp_resp;
        hold_err = 0;
        if (rsp_d > 0) begin
            cmd_valid = 1; cmd_write = ~wr;
            cmd_addr = a ^ 6'h04; cmd_wdata = ~d;
            for (int k = 0; k < rsp_d; k++) begin
                @(negedge clk);
                if (!rsp_valid || cmd_ready || rsp_rdata !== grd ||
                    rsp_resp !== grs) hold_err++;
            end
            chk("rsp_hold", hold_err, 0);
        end
        rsp_ready = 1; cmd_valid = 0;
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_drop", 32'(rsp_valid), 0);
    endtask

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          awd, wdd, bd, ard, rd, rspd;
        logic [1:0]  resp;
        logic [31:0] erd;
        logic [1:0]  ers;
        int          elat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [31:0] grd, exp_rd;
        logic [1:0]  grs, rsp;
        int          lat, nb0, idx, cnt;
        bit          wr;
        logic [31:0] d;
        logic [3:0]  s;

        vecs[0] = '{1, 6'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0,
                    2'b00, 32'h0, 2'b00, 3};
        vecs[1] = '{0, 6'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0,
                    2'b00, 32'hDEADBEEF, 2'b00, 3};
        vecs[2] = '{1, 6'h30, 32'h00001234, 4'hF, 0, 2, 1, 0, 0, 0,
                    2'b00, 32'h0, 2'b00, 0};
        vecs[3] = '{0, 6'h30, 32'h0, 4'h0, 0, 0, 0, 0, 2, 0,
                    2'b00, 32'h00001234, 2'b00, 0};
        vecs[4] = '{1, 6'h10, 32'h11223344, 4'h3, 1, 1, 0, 0, 0, 0,
                    2'b00, 32'h0, 2'b00, 0};
        vecs[5] = '{0, 6'h10, 32'h0, 4'h0, 0, 0, 0, 1, 0, 0,
                    2'b00, 32'hDEAD3344, 2'b00, 0};
        vecs[6] = '{1, 6'h18, 32'hA5A5A5A5, 4'hC, 0, 0, 0, 0, 0, 0,
                    2'b10, 32'h0, 2'b10, 0};
        vecs[7] = '{0, 6'h18, 32'h0, 4'h0, 0, 0, 0, 0, 0, 5,
                    2'b00, 32'hA5A50000, 2'b00, 0};
        vecs[8] = '{0, 6'h3C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0,
                    2'b10, 32'h0, 2'b10, 0};

        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        rstn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
`ifdef AXIL_CMD_MASTER_ERR_STICKY_EN
        err_clear = 0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, rsp_valid}), 0);
        chk("rst_readys", 32'({bready, rready}), 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_resp", 32'(rsp_resp), 0);
        chk("prot", 32'({awprot, arprot}), 0);
`ifdef AXIL_CMD_MASTER_ERR_STICKY_EN
        chk("rst_err", 32'(err_sticky), 0);
`endif
        rstn = 1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            aw_d = vecs[i].awd; w_d = vecs[i].wdd; b_d = vecs[i].bd;
            ar_d = vecs[i].ard; r_d = vecs[i].rd; s_resp = vecs[i].resp;
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].ws,
                    vecs[i].rspd, grd, grs, lat);
            if (vecs[i].wr)
                ref_mem[vecs[i].addr[5:2]] =
                    merge(ref_mem[vecs[i].addr[5:2]], vecs[i].wd,
                          vecs[i].ws);
            chk($sformatf("vec%0d_rdata", i), grd, vecs[i].erd);
            chk($sformatf("vec%0d_resp", i), 32'(grs), 32'(vecs[i].ers));
            if (vecs[i].elat != 0)
                chk($sformatf("vec%0d_lat", i), lat, vecs[i].elat);
        end

`ifdef AXIL_CMD_MASTER_ERR_STICKY_EN
        chk("err_set", 32'(err_sticky), 1);
        err_clear = 1;
        @(negedge clk);
        err_clear = 0;
        chk("err_cleared", 32'(err_sticky), 0);
`endif

        // awready late, wready immediate
        aw_d = 3; w_d = 0; b_d = 0; s_resp = 2'b00;
        nb0 = n_b;
        run_txn(1, 6'h24, 32'h0BADF00D, 4'hF, 0, grd, grs, lat);
        ref_mem[9] = 32'h0BADF00D;
        chk("aw_hi_cycles", last_aw_hi, 4);
        chk("w_hi_cycles", last_w_hi, 1);
        repeat (2) @(negedge clk);
        chk("b_count", n_b - nb0, 1);

        // reset while waiting in B; the write must be abandoned
        aw_d = 0; b_d = 5;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 6'h20;
        cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 0;
        cnt = 0;
        while (!bready && cnt < 20) begin
            @(negedge clk); cnt++;
        end
        chk("bready_seen", 32'(bready), 1);
        rstn = 0;
        #1;
        chk("rstB_bready", 32'(bready), 0);
        chk("rstB_rsp_valid", 32'(rsp_valid), 0);
        chk("rstB_cmd_ready", 32'(cmd_ready), 1);
        repeat (2) @(negedge clk);
        rstn = 1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("rstB_no_rsp", cnt, 0);
        b_d = 0;
        run_txn(0, 6'h20, 32'h0, 4'h0, 0, grd, grs, lat);
        chk("rstB_after_read", grd, ref_mem[8]);
        chk("rstB_after_lat", lat, 3);

        // randomized traffic checked against the reference memory
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(1));
            idx = $urandom_range(15);
            d = $urandom;
            s = 4'($urandom_range(15));
            aw_d = $urandom_range(3); w_d = $urandom_range(3);
            b_d = $urandom_range(3); ar_d = $urandom_range(3);
            r_d = $urandom_range(3);
            rsp = ($urandom_range(3) == 0) ? 2'($urandom_range(1, 3))
                                           : 2'b00;
            s_resp = rsp;
            exp_rd = wr ? 32'h0 : ref_mem[idx];
            run_txn(wr, 6'(idx * 4), d, s, $urandom_range(2),
                    grd, grs, lat);
            if (wr) ref_mem[idx] = merge(ref_mem[idx], d, s);
            chk($sformatf("rnd%0d_rdata", t), grd, exp_rd);
            chk($sformatf("rnd%0d_resp", t), 32'(grs), 32'(rsp));
        end

        chk("bus_stability", stab_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 AXI_LITE_ADDR_WIDTH, default 6, AXI-Lite address width; data width is fixed at 32.
REQ-002 clk  in  1  sole clock; all logic on the rising edge.
REQ-003 rstn  in  1  reset, asynchronous and active-low.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  AXI_LITE_ADDR_WIDTH  target byte address.
REQ-008 cmd_wdata  in  32  write data; ignored for reads.
REQ-009 cmd_wstrb  in  4  write byte strobes; ignored for reads.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed.
REQ-012 rsp_rdata  out  32  read data; 0 for writes.
REQ-013 rsp_resp  out  2  captured BRESP/RRESP.
REQ-014 err_sticky  out  1  sticky error flag; exists only when the macro in REQ-033 is defined.
REQ-015 err_clear  in  1  clears err_sticky; exists only when the macro in REQ-033 is defined.
REQ-016 io_control_aw_{awaddr out AW, awprot out 3, awvalid out 1, awready in 1}  AXI-Lite write address channel.
REQ-017 io_control_w_{wdata out 32, wstrb out 4, wvalid out 1, wready in 1}  AXI-Lite write data channel.
REQ-018 io_control_b_{bresp in 2, bvalid in 1, bready out 1}  AXI-Lite write response channel.
REQ-019 io_control_ar_{araddr out AW, arprot out 3, arvalid out 1, arready in 1}  AXI-Lite read address channel.
REQ-020 io_control_r_{rdata in 32, rresp in 2, rvalid in 1, rready out 1}  AXI-Lite read data channel.

Function
REQ-021 FSM states and roles:
- IDLE: cmd_ready=1.
- WRITE: AW and W channels pending.
- B: bready=1.
- AR: arvalid=1.
- R: rready=1.
- RSP: rsp_valid=1.
REQ-022 IDLE: on cmd_valid, capture addr/wdata/wstrb/write; go to WRITE if cmd_write, else AR. AXI valid rises the next cycle.
REQ-023 WRITE: awvalid and wvalid both assert on entry; each drops independently after its own handshake; go to B in the cycle both handshakes are complete, including same-cycle completion.
REQ-024 B: on bvalid, capture bresp into rsp_resp, set rsp_rdata=0, go to RSP.
REQ-025 AR: hold arvalid until arready, then go to R.
REQ-026 R: on rvalid, capture rdata/rresp, go to RSP.
REQ-027 RSP: hold rsp_valid and data stable until rsp_ready, then go to IDLE; at most one transaction is outstanding.
REQ-028 AXI handshakes:
- No valid depends combinationally on any ready.
- Address, data and strobes are stable while valid is high.
- awprot and arprot are constant 3'b000.
REQ-029 All AXI valid/ready outputs and rsp_valid are driven from registers or decoded from the state register, with no input-to-output combinational path.
REQ-030 Minimum latency from command acceptance to rsp_valid with zero-wait slave: write = 3 cycles, read = 3 cycles.

Reset
REQ-031 When rstn is low, asynchronously:
- state = IDLE.
- All AXI valid and ready outputs = 0.
- rsp_valid = 0, rsp_rdata = 0, rsp_resp = 0, err_sticky = 0.
- cmd_ready = 1 once reset is held.
REQ-032 Reset mid-transaction abandons the transaction silently; no response is produced.

Configuration
REQ-033 AXIL_CMD_MASTER_ERR_STICKY_EN, when defined:
- err_sticky is set in the cycle a non-zero bresp/rresp is captured.
- err_sticky is cleared by err_clear.
- A set in the same cycle as err_clear wins.
REQ-034 When AXIL_CMD_MASTER_ERR_STICKY_EN is undefined, err_sticky and err_clear do not exist; all other behaviour is identical.

Verification
REQ-035 Write addr 0x10, data 0xDEADBEEF, wstrb 0xF, zero-wait slave -> awvalid/wvalid one cycle after accept; rsp_valid with rsp_resp=0, rsp_rdata=0.
REQ-036 Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle; awvalid held 4 cycles with stable awaddr; exactly one B handshake.
REQ-037 Read addr 0x30, slave returns rdata 0x00001234 after 2-cycle rvalid delay -> rsp_rdata=0x00001234, rsp_resp=0.
REQ-038 Read addr 0x3C, slave returns rresp=2'b10 -> rsp_resp=2'b10; err_sticky=1 with macro defined; err_clear pulse clears it.
REQ-039 rsp_ready held low 5 cycles, new cmd_valid presented -> cmd_ready=0 and response stable until rsp_ready.
REQ-040 rstn low while in B -> bready=0 immediately, no rsp_valid; next command completes normally.
